// File: rtl/rr_arb_pkg.sv
// Shared definitions for the weighted-slice round-robin arbiter.
//   arb_state_e   : arbiter FSM states (no holder / one holder)
//   MIN_SLICE     : shortest slice a holder can be given, in cycles
//   onehot_to_idx : index of the set bit of a one-hot vector (up to 16 bits)
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  localparam int MIN_SLICE = 1;

  // OR-ing indices is exact for one-hot input and yields 0 for all-zero input.
  function automatic int onehot_to_idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req     : candidate request vector (holder already masked by caller)
//   ptr     : index that has highest priority this search
//   win     : one-hot winner, zero when no candidate
//   any_req : at least one candidate present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win,
  output logic             any_req
);

  int   idx;
  logic found;

  // Scan ptr, ptr+1, ... wrapping; first requester seen wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_weighted_slices.sv
// Round-robin arbiter with a programmable time slice per requester.
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   req           : request vector, bit i = requester i
//   slice_len     : field i = slice length of requester i in cycles (0 acts as 1)
//   gnt           : registered one-hot grant
//   gnt_valid     : a grant is active
//   gnt_id        : index of the current holder
//   slice_expired : one-cycle pulse when the holder is pre-empted by slice expiry
module rr_arbiter_weighted_slices
  import rr_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SLICE_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*SLICE_W-1:0]   slice_len,
  output logic [N_REQ-1:0]           gnt,
  output logic                       gnt_valid,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       slice_expired
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_e         state, state_n;
  logic [SLICE_W-1:0] cnt, cnt_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [N_REQ-1:0]   gnt_n;
  logic [ID_W-1:0]    gnt_id_n;
  logic               exp_n;

  logic [N_REQ-1:0]   pick_req;
  logic [ID_W-1:0]    pick_ptr;
  logic [N_REQ-1:0]   win;
  logic               any_req;
  logic [15:0]        win16;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    next_after_h;
  logic [SLICE_W-1:0] win_load;
  logic [SLICE_W-1:0] hold_load;

  // Counter holds remaining cycles minus one; a zero-length slice acts as MIN_SLICE.
  function automatic logic [SLICE_W-1:0] slice_load(input logic [SLICE_W-1:0] s);
    if (s < SLICE_W'(MIN_SLICE)) return '0;
    return s - SLICE_W'(MIN_SLICE);
  endfunction

  assign next_after_h = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  // While granting, the holder is masked and the search starts just after it,
  // so it is only reconsidered after every other requester. In IDLE the
  // plain request vector is searched from ptr.
  assign pick_req = (state == ST_GRANT) ? (req & ~gnt) : req;
  assign pick_ptr = (state == ST_GRANT) ? next_after_h : ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (pick_req),
    .ptr     (pick_ptr),
    .win     (win),
    .any_req (any_req)
  );

  always_comb begin
    win16             = '0;
    win16[N_REQ-1:0]  = win;
  end

  assign win_idx   = ID_W'(onehot_to_idx(win16));
  assign win_load  = slice_load(slice_len[int'(win_idx)*SLICE_W +: SLICE_W]);
  assign hold_load = slice_load(slice_len[int'(gnt_id)*SLICE_W +: SLICE_W]);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ptr_n    = ptr;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    exp_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n  = ST_GRANT;
          gnt_n    = win;
          gnt_id_n = win_idx;
          cnt_n    = win_load;
        end
      end
      ST_GRANT: begin
        if (!req[gnt_id]) begin
          // Early release: hand over in the same cycle, no idle bubble.
          ptr_n = next_after_h;
          if (any_req) begin
            gnt_n    = win;
            gnt_id_n = win_idx;
            cnt_n    = win_load;
          end else begin
            state_n  = ST_IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
            cnt_n    = '0;
          end
        end else if (cnt == '0) begin
          if (any_req) begin
            ptr_n    = next_after_h;
            gnt_n    = win;
            gnt_id_n = win_idx;
            cnt_n    = win_load;
            exp_n    = 1'b1;
          end else begin
            // Uncontended: keep the grant and start a fresh slice.
            cnt_n = hold_load;
          end
        end else begin
          cnt_n = cnt - SLICE_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptr           <= '0;
      gnt           <= '0;
      gnt_id        <= '0;
      slice_expired <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ptr           <= ptr_n;
      gnt           <= gnt_n;
      gnt_id        <= gnt_id_n;
      slice_expired <= exp_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule
